ste_lmc1992: RTL and testbench

// Downstream stage of the STE DMA sound block: emulates the LMC1992 volume/tone controller behind the microwire port.
// - Deserialises the microwire bit stream (mw_clk mask, mw_data, mw_done) into LMC1992 commands.
// - Mixes DMA audio with the YM2149 output and applies master and left/right attenuation.
// - Drives 16-bit signed samples and 1-bit sigma-delta DAC pins.
// - Bass/treble are latched and exported for a later tone stage; they are not applied here.

---
 rtl/ste_lmc1992_if.sv | 28 ++
 rtl/ste_lmc1992.sv | 183 ++++++++++++++++++
 tb/tb_ste_lmc1992.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ste_lmc1992_if.sv
// Port bundle for the LMC1992 stage: microwire receive, audio inputs and
// processed sample/DAC/tone-setting outputs.
interface ste_lmc1992_if;
    logic        mw_bit_stb;
    logic        mw_clk;
    logic        mw_data;
    logic        mw_done;
    logic [7:0]  dma_l;
    logic [7:0]  dma_r;
    logic [7:0]  ym_audio;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        dac_l;
    logic        dac_r;
    logic [3:0]  bass;
    logic [3:0]  treble;
    logic [1:0]  mix_mode;

    modport master (
        output mw_bit_stb, mw_clk, mw_data, mw_done, dma_l, dma_r, ym_audio,
        input  out_l, out_r, dac_l, dac_r, bass, treble, mix_mode
    );

    modport slave (
        input  mw_bit_stb, mw_clk, mw_data, mw_done, dma_l, dma_r, ym_audio,
        output out_l, out_r, dac_l, dac_r, bass, treble, mix_mode
    );
endinterface

// File: rtl/ste_lmc1992.sv
// LMC1992 volume/tone controller emulation: microwire command receiver,
// DMA/YM mixer with 2 dB attenuation steps, and per-channel sigma-delta DACs.
module ste_lmc1992 (
    input  logic         clk32,
    input  logic         reset,
    ste_lmc1992_if.slave bus
);

    // Splits an attenuation in 2 dB steps into a 6 dB shift count and a mantissa.
    function automatic logic [13:0] gain_split(input logic [5:0] n);
        logic [5:0] q;
        logic [5:0] r;
        logic [8:0] m;
        q = n / 6'd3;
        r = n - (q * 6'd3);
        case (r)
            6'd0:    m = 9'd256;
            6'd1:    m = 9'd203;
            default: m = 9'd161;
        endcase
        return {q[4:0], m};
    endfunction

    function automatic logic [3:0] clamp_tone(input logic [3:0] d);
        return (d > 4'd12) ? 4'd12 : d;
    endfunction

    function automatic logic [4:0] clamp_side(input logic [4:0] d);
        return (d > 5'd20) ? 5'd20 : d;
    endfunction

    logic [10:0] sr_r;
    logic [3:0]  cnt_r;
    logic        done_d_r;
    logic [10:0] sr_next_s;
    logic [3:0]  cnt_next_s;
    logic        shift_s;
    logic        done_edge_s;
    logic        cmd_ok_s;

    logic [5:0]  master_r;
    logic [4:0]  left_r;
    logic [4:0]  right_r;
    logic [3:0]  bass_r;
    logic [3:0]  treble_r;
    logic [1:0]  mix_r;

    logic [7:0]         dma_s      [2];
    logic [4:0]         side_s     [2];
    logic [8:0]         s_next_s   [2];
    logic [5:0]         n_s        [2];
    logic [13:0]        split_s    [2];
    logic [17:0]        prod_s     [2];
    logic [5:0]         shamt_s    [2];
    logic [16:0]        sd_sum_s   [2];
    logic signed [8:0]  s_r        [2];
    logic [4:0]         k_r        [2];
    logic [8:0]         mant_r     [2];
    logic signed [17:0] p_r        [2];
    logic [4:0]         k2_r       [2];
    logic [15:0]        out_r      [2];
    logic [15:0]        acc_r      [2];
    logic               dac_r      [2];

    assign shift_s     = bus.mw_bit_stb & bus.mw_clk;
    assign done_edge_s = bus.mw_done & ~done_d_r;
    // A bit arriving together with the done edge is part of the command being decoded.
    assign cmd_ok_s    = done_edge_s && (cnt_next_s >= 4'd11) && (sr_next_s[10:9] == 2'b10);

    // Next shift-register / bit-count values for the current microwire period.
    always_comb begin
        sr_next_s  = sr_r;
        cnt_next_s = cnt_r;
        if (shift_s) begin
            sr_next_s = {sr_r[9:0], bus.mw_data};
            if (cnt_r == 4'd15) begin
                cnt_next_s = 4'd15;
            end else begin
                cnt_next_s = cnt_r + 4'd1;
            end
        end else begin
            sr_next_s  = sr_r;
            cnt_next_s = cnt_r;
        end
    end

    // Microwire receiver state; a done edge always starts a fresh transfer.
    always_ff @(posedge clk32) begin
        if (reset) begin
            sr_r     <= 11'd0;
            cnt_r    <= 4'd0;
            done_d_r <= 1'b0;
        end else begin
            done_d_r <= bus.mw_done;
            if (done_edge_s) begin
                sr_r  <= 11'd0;
                cnt_r <= 4'd0;
            end else begin
                sr_r  <= sr_next_s;
                cnt_r <= cnt_next_s;
            end
        end
    end

    // Command decode into the LMC1992 register file, with range clamping.
    always_ff @(posedge clk32) begin
        if (reset) begin
            master_r <= 6'd40;
            left_r   <= 5'd20;
            right_r  <= 5'd20;
            bass_r   <= 4'd6;
            treble_r <= 4'd6;
            mix_r    <= 2'b01;
        end else if (cmd_ok_s) begin
            case (sr_next_s[8:6])
                3'b000:  mix_r    <= sr_next_s[1:0];
                3'b001:  bass_r   <= clamp_tone(sr_next_s[3:0]);
                3'b010:  treble_r <= clamp_tone(sr_next_s[3:0]);
                3'b011:  master_r <= (sr_next_s[5:0] > 6'd40) ? 6'd40 : sr_next_s[5:0];
                3'b100:  right_r  <= clamp_side(sr_next_s[4:0]);
                3'b101:  left_r   <= clamp_side(sr_next_s[4:0]);
                default: mix_r    <= mix_r;
            endcase
        end else begin
            mix_r <= mix_r;
        end
    end

    assign dma_s[0]  = bus.dma_l;
    assign dma_s[1]  = bus.dma_r;
    assign side_s[0] = left_r;
    assign side_s[1] = right_r;

    // Per-channel datapath arithmetic; 9-bit wraparound is exact since the mix stays in -256..254.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            if (mix_r == 2'b01) begin
                s_next_s[c] = {1'b0, dma_s[c]} + {1'b0, bus.ym_audio} - 9'd256;
            end else begin
                s_next_s[c] = {1'b0, dma_s[c]} - 9'd128;
            end
            n_s[c]      = (6'd40 - master_r) + (6'd20 - {1'b0, side_s[c]});
            split_s[c]  = gain_split(n_s[c]);
            prod_s[c]   = {{9{s_r[c][8]}}, s_r[c]} * {9'd0, mant_r[c]};
            shamt_s[c]  = {1'b0, k2_r[c]} + 6'd1;
            sd_sum_s[c] = {1'b0, acc_r[c]} + {1'b0, out_r[c] ^ 16'h8000};
        end
    end

    // Three-stage gain pipeline followed by the first-order sigma-delta modulators.
    always_ff @(posedge clk32) begin
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                s_r[c]    <= 9'sd0;
                k_r[c]    <= 5'd0;
                mant_r[c] <= 9'd0;
                p_r[c]    <= 18'sd0;
                k2_r[c]   <= 5'd0;
                out_r[c]  <= 16'd0;
                acc_r[c]  <= 16'd0;
                dac_r[c]  <= 1'b0;
            end else begin
                s_r[c]    <= s_next_s[c];
                k_r[c]    <= split_s[c][13:9];
                mant_r[c] <= split_s[c][8:0];
                p_r[c]    <= prod_s[c];
                k2_r[c]   <= k_r[c];
                out_r[c]  <= 16'(p_r[c] >>> shamt_s[c]);
                acc_r[c]  <= sd_sum_s[c][15:0];
                dac_r[c]  <= sd_sum_s[c][16];
            end
        end
    end

    assign bus.out_l    = out_r[0];
    assign bus.out_r    = out_r[1];
    assign bus.dac_l    = dac_r[0];
    assign bus.dac_r    = dac_r[1];
    assign bus.bass     = bass_r;
    assign bus.treble   = treble_r;
    assign bus.mix_mode = mix_r;

endmodule

// File: tb/tb_ste_lmc1992.sv
// Directed bench for ste_lmc1992: microwire commands, gain/mix results via a
// scoreboard queue, and sigma-delta density checks.
`timescale 1ns/1ps
module tb_ste_lmc1992;
    logic clk32 = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] exp_q[$];

    ste_lmc1992_if bus ();

    ste_lmc1992 dut (
        .clk32 (clk32),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #16 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    endtask

    // Shift out 16 bits MSB first with a per-bit mask; optionally end on a bit+done cycle.
    task automatic send_word(input logic [15:0] data, input logic [15:0] mask, input bit done_on_last);
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk32);
            bus.mw_bit_stb = 1'b1;
            bus.mw_clk     = mask[i];
            bus.mw_data    = data[i];
            bus.mw_done    = done_on_last && (i == 0);
            @(negedge clk32);
            bus.mw_bit_stb = 1'b0;
            bus.mw_clk     = 1'b0;
        end
        @(negedge clk32);
        bus.mw_done = 1'b1;
        repeat (2) @(negedge clk32);
        bus.mw_done = 1'b0;
        repeat (4) @(negedge clk32);
    endtask

    task automatic play(input string tag, input logic [7:0] dl, input logic [7:0] dr,
                        input logic [7:0] ym, input logic [15:0] el, input logic [15:0] er);
        logic [31:0] e;
        @(negedge clk32);
        bus.dma_l    = dl;
        bus.dma_r    = dr;
        bus.ym_audio = ym;
        exp_q.push_back({el, er});
        repeat (3) @(posedge clk32);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_l"}, bus.out_l, e[31:16]);
        chk({tag, "_r"}, bus.out_r, e[15:0]);
    endtask

    task automatic dac_density(input string tag, input int lo, input int hi);
        int ones_l;
        int ones_r;
        ones_l = 0;
        ones_r = 0;
        repeat (8) @(posedge clk32);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk32);
            ones_l += int'(bus.dac_l);
            ones_r += int'(bus.dac_r);
        end
        chk_range({tag, "_l"}, ones_l, lo, hi);
        chk_range({tag, "_r"}, ones_r, lo, hi);
    endtask

    initial begin
        bus.mw_bit_stb = 1'b0;
        bus.mw_clk     = 1'b0;
        bus.mw_data    = 1'b0;
        bus.mw_done    = 1'b0;
        bus.dma_l      = 8'h80;
        bus.dma_r      = 8'h80;
        bus.ym_audio   = 8'h80;
        repeat (4) @(posedge clk32);
        #1;
        chk("rst_out_l", bus.out_l, 16'h0000);
        chk("rst_out_r", bus.out_r, 16'h0000);
        chk("rst_dac", {14'd0, bus.dac_l, bus.dac_r}, 16'h0000);

        // Reset release with a new sample: visible exactly at the third edge.
        @(negedge clk32);
        reset     = 1'b0;
        bus.dma_l = 8'hC0;
        bus.dma_r = 8'hC0;
        exp_q.push_back({16'h2000, 16'h2000});
        repeat (2) @(posedge clk32);
        #1;
        chk("lat2_l", bus.out_l, 16'h0000);
        @(posedge clk32);
        #1;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("t1_l", bus.out_l, e[31:16]);
            chk("t1_r", bus.out_r, e[15:0]);
        end
        chk("def_bass", {12'd0, bus.bass}, 16'd6);
        chk("def_treble", {12'd0, bus.treble}, 16'd6);
        chk("def_mix", {14'd0, bus.mix_mode}, 16'd1);

        send_word(16'h04E2, 16'h07FF, 1'b0);
        play("t2_master34", 8'hC0, 8'hC0, 8'h80, 16'h0800, 16'h0800);
        send_word(16'h0553, 16'h07FF, 1'b0);
        play("t3_left19_m34", 8'hC0, 8'hC0, 8'h80, 16'h0658, 16'h0800);
        send_word(16'h04E8, 16'h07FF, 1'b0);
        play("t3_left19_m40", 8'hC0, 8'hC0, 8'h80, 16'h1960, 16'h2000);
        send_word(16'h0554, 16'h07FF, 1'b0);
        play("left20", 8'hC0, 8'hC0, 8'h80, 16'h2000, 16'h2000);

        send_word(16'h02E2, 16'h07FF, 1'b0);
        play("t4_bad_addr", 8'hC0, 8'hC0, 8'h80, 16'h2000, 16'h2000);
        send_word(16'h0443, 16'h03FF, 1'b0);
        chk("t4_ten_bits", {12'd0, bus.bass}, 16'd6);

        send_word(16'hF443, 16'hFFFF, 1'b0);
        chk("last11_bass3", {12'd0, bus.bass}, 16'd3);
        send_word(16'h048F, 16'h07FF, 1'b0);
        chk("treble_clamp", {12'd0, bus.treble}, 16'd12);
        send_word(16'h044D, 16'h07FF, 1'b0);
        chk("bass_clamp", {12'd0, bus.bass}, 16'd12);
        send_word(16'h0445, 16'h07FF, 1'b1);
        chk("bit_with_done", {12'd0, bus.bass}, 16'd5);
        send_word(16'h893F, 16'hFFE0, 1'b0);
        chk("masked_tail", {12'd0, bus.bass}, 16'd9);

        send_word(16'h04E2, 16'h07FF, 1'b0);
        send_word(16'h04FF, 16'h07FF, 1'b0);
        play("t5_master63", 8'hC0, 8'hC0, 8'h80, 16'h2000, 16'h2000);
        play("t5_mix01", 8'h80, 8'h80, 8'hFF, 16'h3F80, 16'h3F80);
        send_word(16'h0402, 16'h07FF, 1'b0);
        chk("mix_rd", {14'd0, bus.mix_mode}, 16'd2);
        play("t5_mix10", 8'h80, 8'h80, 8'hFF, 16'h0000, 16'h0000);
        send_word(16'h04C0, 16'h07FF, 1'b0);
        play("t5_silence", 8'hC0, 8'hC0, 8'h80, 16'h0000, 16'h0000);

        send_word(16'h04E8, 16'h07FF, 1'b0);
        send_word(16'h0401, 16'h07FF, 1'b0);
        play("t6_zero", 8'h80, 8'h80, 8'h80, 16'h0000, 16'h0000);
        dac_density("t6_dac_half", 511, 513);
        play("t6_4000", 8'hC0, 8'hC0, 8'hC0, 16'h4000, 16'h4000);
        dac_density("t6_dac_3q", 767, 769);

        // Reset in the middle of a transfer, then a fresh command.
        send_word(16'h04E2, 16'h07FF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk32);
            bus.mw_bit_stb = 1'b1;
            bus.mw_clk     = 1'b1;
            bus.mw_data    = 1'(i & 1);
            @(negedge clk32);
            bus.mw_bit_stb = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk32);
        reset = 1'b0;
        send_word(16'h0447, 16'h07FF, 1'b0);
        chk("t4_rst_bass7", {12'd0, bus.bass}, 16'd7);
        chk("t4_rst_treble", {12'd0, bus.treble}, 16'd6);
        play("t4_rst_gain", 8'hC0, 8'hC0, 8'h80, 16'h2000, 16'h2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
